// File: rtl/video_timing_pkg.sv
// ============================================================================
// Module  : video_timing_pkg
// Purpose : Standard raster timing constants and counter-width helper.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package video_timing_pkg;

    typedef struct packed {
        int h_active;
        int h_fp;
        int h_sync;
        int h_bp;
        int v_active;
        int v_fp;
        int v_sync;
        int v_bp;
    } timing_t;

    localparam timing_t MODE_640X480_60 = '{
        h_active: 640, h_fp: 16, h_sync: 96, h_bp: 48,
        v_active: 480, v_fp: 10, v_sync: 2,  v_bp: 33
    };

    localparam timing_t MODE_800X600_60 = '{
        h_active: 800, h_fp: 40, h_sync: 128, h_bp: 88,
        v_active: 600, v_fp: 1,  v_sync: 4,   v_bp: 23
    };

    localparam timing_t MODE_1280X720_60 = '{
        h_active: 1280, h_fp: 110, h_sync: 40, h_bp: 220,
        v_active: 720,  v_fp: 5,   v_sync: 5,  v_bp: 20
    };

    // Bits needed to hold counts 0..total-1.
    function automatic int cnt_width(input int total);
        return (total < 2) ? 1 : $clog2(total);
    endfunction

endpackage

`default_nettype wire

// File: rtl/timing_axis.sv
// ============================================================================
// Module  : timing_axis
// Purpose : One raster axis: wrapping counter, sync window and active window.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module timing_axis #(
    parameter int TOTAL      = 800,
    parameter int ACTIVE     = 640,
    parameter int SYNC_START = 656,
    parameter int SYNC_LEN   = 96,
    parameter bit POL        = 1'b0,
    parameter int CNT_W      = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step,
    output logic [CNT_W-1:0] count,
    output logic             wrap,
    output logic             sync,
    output logic             active_next
);

    localparam logic [CNT_W-1:0] C_LAST    = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] C_ACT_END = CNT_W'(ACTIVE);
    localparam logic [CNT_W-1:0] C_SYNC_LO = CNT_W'(SYNC_START);
    localparam logic [CNT_W-1:0] C_SYNC_HI = CNT_W'(SYNC_START + SYNC_LEN - 1);

    logic [CNT_W-1:0] count_next;
    logic             sync_next;

    // Flags are derived from the next count so that, once registered, they
    // describe the same position as the registered count.
    always_comb begin
        wrap       = step && (count == C_LAST);
        count_next = count;
        if (step) begin
            count_next = wrap ? '0 : count + 1'b1;
        end
        active_next = (count_next < C_ACT_END);
        sync_next   = ((count_next >= C_SYNC_LO) && (count_next <= C_SYNC_HI)) ? POL : ~POL;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            sync  <= ~POL;
        end else begin
            count <= count_next;
            sync  <= sync_next;
        end
    end

endmodule

`default_nettype wire

// File: rtl/video_timing_gen.sv
// ============================================================================
// Module  : video_timing_gen
// Purpose : Raster timing generator with zero-skew registered sync/active/pulses.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int H_ACTIVE = MODE_640X480_60.h_active,
    parameter int H_FP     = MODE_640X480_60.h_fp,
    parameter int H_SYNC   = MODE_640X480_60.h_sync,
    parameter int H_BP     = MODE_640X480_60.h_bp,
    parameter int V_ACTIVE = MODE_640X480_60.v_active,
    parameter int V_FP     = MODE_640X480_60.v_fp,
    parameter int V_SYNC   = MODE_640X480_60.v_sync,
    parameter int V_BP     = MODE_640X480_60.v_bp,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CNT_W    = 10
) (
    input  logic             clk_25,
    input  logic             rst,
    input  logic             ce,
    output logic [CNT_W-1:0] x_count,
    output logic [CNT_W-1:0] y_count,
    output logic             hsync,
    output logic             vsync,
    output logic             active_pixel,
    output logic             line_start,
    output logic             frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int MAX_TOTAL = (H_TOTAL > V_TOTAL) ? H_TOTAL : V_TOTAL;

    if (CNT_W < cnt_width(MAX_TOTAL)) begin : g_cnt_w_too_small
        $error("video_timing_gen: CNT_W=%0d cannot hold a count of %0d", CNT_W, MAX_TOTAL);
    end

    logic h_wrap;
    logic v_wrap;
    logic h_active_next;
    logic v_active_next;

    timing_axis #(
        .TOTAL      (H_TOTAL),
        .ACTIVE     (H_ACTIVE),
        .SYNC_START (H_ACTIVE + H_FP),
        .SYNC_LEN   (H_SYNC),
        .POL        (HS_POL),
        .CNT_W      (CNT_W)
    ) u_h_axis (
        .clk         (clk_25),
        .rst         (rst),
        .step        (ce),
        .count       (x_count),
        .wrap        (h_wrap),
        .sync        (hsync),
        .active_next (h_active_next)
    );

    // The vertical axis only moves on a horizontal wrap, so vsync edges
    // always coincide with x returning to 0.
    timing_axis #(
        .TOTAL      (V_TOTAL),
        .ACTIVE     (V_ACTIVE),
        .SYNC_START (V_ACTIVE + V_FP),
        .SYNC_LEN   (V_SYNC),
        .POL        (VS_POL),
        .CNT_W      (CNT_W)
    ) u_v_axis (
        .clk         (clk_25),
        .rst         (rst),
        .step        (h_wrap),
        .count       (y_count),
        .wrap        (v_wrap),
        .sync        (vsync),
        .active_next (v_active_next)
    );

    always_ff @(posedge clk_25) begin
        if (rst) begin
            active_pixel <= 1'b1;
            line_start   <= 1'b0;
            frame_start  <= 1'b0;
        end else begin
            active_pixel <= h_active_next && v_active_next;
            line_start   <= h_wrap;
            frame_start  <= h_wrap && v_wrap;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_video_timing_gen.sv
// ============================================================================
// Module  : tb_video_timing_gen
// Purpose : Randomized scoreboard bench against a linear-pixel-index raster model.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_video_timing_gen;

    localparam int HA = 8;
    localparam int HF = 2;
    localparam int HS = 3;
    localparam int HB = 2;
    localparam int VA = 5;
    localparam int VF = 1;
    localparam int VS = 2;
    localparam int VB = 2;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam bit HP = 1'b1;
    localparam bit VP = 1'b0;
    localparam int CW = 4;

    logic          clk_25 = 1'b0;
    logic          rst;
    logic          ce;
    logic [CW-1:0] x_count;
    logic [CW-1:0] y_count;
    logic          hsync;
    logic          vsync;
    logic          active_pixel;
    logic          line_start;
    logic          frame_start;

    typedef struct {
        int x;
        int y;
        bit hs;
        bit vs;
        bit act;
        bit ls;
        bit fs;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   passes = 0;
    int   mx = 0;
    int   my = 0;

    video_timing_gen #(
        .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
        .HS_POL   (HP), .VS_POL (VP), .CNT_W (CW)
    ) dut (
        .clk_25       (clk_25),
        .rst          (rst),
        .ce           (ce),
        .x_count      (x_count),
        .y_count      (y_count),
        .hsync        (hsync),
        .vsync        (vsync),
        .active_pixel (active_pixel),
        .line_start   (line_start),
        .frame_start  (frame_start)
    );

    always #5 clk_25 = ~clk_25;

    function automatic exp_t expect_at(input int x, input int y, input bit ls, input bit fs);
        exp_t e;
        e.x   = x;
        e.y   = y;
        e.hs  = (x >= HA + HF && x < HA + HF + HS) ? HP : !HP;
        e.vs  = (y >= VA + VF && y < VA + VF + VS) ? VP : !VP;
        e.act = (x < HA) && (y < VA);
        e.ls  = ls;
        e.fs  = fs;
        return e;
    endfunction

    // Position is tracked as a flat pixel index within the frame.
    task automatic drive(input bit r, input bit c);
        int flat;
        bit ls;
        bit fs;
        ls = 1'b0;
        fs = 1'b0;
        @(negedge clk_25);
        rst = r;
        ce  = c;
        if (r) begin
            mx = 0;
            my = 0;
        end else if (c) begin
            flat = (my * HT + mx + 1) % (HT * VT);
            mx   = flat % HT;
            my   = flat / HT;
            ls   = (mx == 0);
            fs   = (flat == 0);
        end
        sbq.push_back(expect_at(mx, my, ls, fs));
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk_25);
            #1;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                checks++;
                if (int'(x_count) == e.x && int'(y_count) == e.y && hsync == e.hs &&
                    vsync == e.vs && active_pixel == e.act && line_start == e.ls &&
                    frame_start == e.fs) begin
                    passes++;
                end else begin
                    $display("FAIL pixel_state t=%0t: got x=%0d y=%0d hs=%b vs=%b act=%b ls=%b fs=%b, expected x=%0d y=%0d hs=%b vs=%b act=%b ls=%b fs=%b",
                             $time, x_count, y_count, hsync, vsync, active_pixel, line_start, frame_start,
                             e.x, e.y, e.hs, e.vs, e.act, e.ls, e.fs);
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        ce  = 1'b0;
        repeat (3) drive(1'b1, 1'($urandom_range(0, 1)));
        repeat (2 * HT * VT + 7) drive(1'b0, 1'b1);
        repeat (1500) drive(1'b0, 1'($urandom_range(0, 1)));
        // Reset landing inside both sync windows, then a full frame of ce=1.
        for (int i = 0; i < 2 * HT * VT && !(mx == HA + HF + 1 && my == VA + VF); i++) begin
            drive(1'b0, 1'b1);
        end
        drive(1'b1, 1'b0);
        repeat (HT * VT + 5) drive(1'b0, 1'b1);
        repeat (3000) drive($urandom_range(0, 299) == 0, $urandom_range(0, 1) != 0);
        drive(1'b1, 1'b1);
        repeat (HT * VT + 5) drive(1'b0, 1'b1);
        drive(1'b0, 1'b0);
        for (int i = 0; i < 10 && sbq.size() != 0; i++) begin
            @(posedge clk_25);
            #2;
        end
        if (sbq.size() != 0) begin
            checks++;
            $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", sbq.size());
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

`default_nettype wire
